window_fetch: RTL and testbench

//  Read-side client of the picture memory port (re_p/read_addressp/qp) in the RAM block.
//  - Walks a MATRIX x MATRIX feature map stored row-major at base_addr.
//  - For every 3x3 convolution window, issues 9 single-pixel reads and packs the
//    9 returned pixels into one SIZE_9-wide word.
//  - Hands each packed word to the conv core over a valid/ready handshake.

---
 rtl/window_fetch.sv | 223 ++++++++++++++++++++++
 tb/tb_window_fetch.sv | 296 +++++++++++++++++++++++++++++
 2 files changed

// File: rtl/window_fetch.sv
// window_fetch: streams every 3x3 window of a MATRIX x MATRIX map out of the picture RAM port, packed into one word (ZERO_PAD_EN adds 1-pixel zero padding).
// Latency: 9 read cycles + 1 capture cycle per window, so a window appears 11 cycles after the previous accept.
// Backpressure: win/win_valid hold in HOLD until win_ready; no reads are issued while a window is held.
module window_fetch #(
   parameter int SIZE             = 13,
   parameter int SIZE_9           = 117,
   parameter int SIZE_address_pix = 13,
   parameter int MATRIX           = 28
) (
   input  logic                        clk,
   input  logic                        rst_n,
   input  logic                        go,
   input  logic [SIZE_address_pix-1:0] base_addr,
   output logic                        re_p,
   output logic [SIZE_address_pix-1:0] read_addressp,
   input  logic [SIZE-1:0]             qp,
   output logic [SIZE_9-1:0]           win,
   output logic                        win_valid,
   input  logic                        win_ready,
   output logic                        done,
   output logic                        busy
);

   localparam int AW = SIZE_address_pix;
   localparam int CW = $clog2(MATRIX + 1);
`ifdef ZERO_PAD_EN
   localparam int LAST_POS = MATRIX - 1;
`else
   localparam int LAST_POS = MATRIX - 3;
`endif
   localparam logic [CW-1:0] POS_MAX = CW'(LAST_POS);
   localparam logic [AW:0]   MAT_W   = (AW+1)'(MATRIX);

   typedef enum logic [2:0] {S_IDLE, S_READ, S_LAST, S_HOLD, S_DONE} state_t;

   state_t            state_q, state_d;
   logic [3:0]        tap_q, tap_d;
   logic [CW-1:0]     row_q, row_d, col_q, col_d;
   logic [AW-1:0]     base_q, base_d;
   logic              re_p_q, re_p_d;
   logic [AW-1:0]     raddr_q, raddr_d;
   logic [SIZE_9-1:0] win_q, win_d;
   logic              win_valid_q, win_valid_d;
   logic              done_q, done_d;
   logic              busy_q, busy_d;
`ifdef ZERO_PAD_EN
   logic              rd_dly_q, rd_dly_d;
`endif

   logic              issue_en;
   logic [AW-1:0]     issue_base;
   logic [CW-1:0]     issue_r, issue_c;
   logic [3:0]        issue_k;
   logic [AW:0]       issue;
   logic              cap_en;
   logic [3:0]        cap_k;
   logic [SIZE-1:0]   cap_dat;

   // Returns {in_range, address} for tap k of window (row, col).
   function automatic logic [AW:0] tap_issue(input logic [AW-1:0] base,
                                             input logic [CW-1:0] row,
                                             input logic [CW-1:0] col,
                                             input logic [3:0]    k);
      logic [AW:0] di, dj, rr, cc, addr;
      logic        ok;
      if (k >= 4'd6)      di = (AW+1)'(2);
      else if (k >= 4'd3) di = (AW+1)'(1);
      else                di = '0;
      dj = (AW+1)'(k) - di * (AW+1)'(3);
      rr = (AW+1)'(row) + di;
      cc = (AW+1)'(col) + dj;
`ifdef ZERO_PAD_EN
      // rr/cc are the padded coordinates; 0 and MATRIX+1 fall in the zero border.
      ok   = (rr != '0) && (rr <= MAT_W) && (cc != '0) && (cc <= MAT_W);
      addr = {1'b0, base} + (rr - (AW+1)'(1)) * MAT_W + (cc - (AW+1)'(1));
`else
      ok   = 1'b1;
      addr = {1'b0, base} + rr * MAT_W + cc;
`endif
      return {ok, addr[AW-1:0]};
   endfunction

`ifdef ZERO_PAD_EN
   assign cap_dat = rd_dly_q ? qp : '0;
`else
   assign cap_dat = qp;
`endif

   always_comb begin
      state_d     = state_q;
      tap_d       = tap_q;
      row_d       = row_q;
      col_d       = col_q;
      base_d      = base_q;
      re_p_d      = 1'b0;
      raddr_d     = raddr_q;
      win_d       = win_q;
      win_valid_d = win_valid_q;
      done_d      = 1'b0;
      issue_en    = 1'b0;
      issue_base  = base_q;
      issue_r     = row_q;
      issue_c     = col_q;
      issue_k     = '0;
      cap_en      = 1'b0;
      cap_k       = tap_q - 4'd1;

      case (state_q)
         S_IDLE: begin
            if (go) begin
               base_d     = base_addr;
               row_d      = '0;
               col_d      = '0;
               tap_d      = '0;
               state_d    = S_READ;
               issue_en   = 1'b1;
               issue_base = base_addr;
               issue_r    = '0;
               issue_c    = '0;
            end
         end
         S_READ: begin
            cap_en = (tap_q != 4'd0);
            if (tap_q == 4'd8) begin
               tap_d   = '0;
               state_d = S_LAST;
            end else begin
               tap_d    = tap_q + 4'd1;
               issue_en = 1'b1;
               issue_k  = tap_q + 4'd1;
            end
         end
         S_LAST: begin
            cap_en      = 1'b1;
            cap_k       = 4'd8;
            win_valid_d = 1'b1;
            state_d     = S_HOLD;
         end
         S_HOLD: begin
            if (win_ready) begin
               win_valid_d = 1'b0;
               if (row_q == POS_MAX && col_q == POS_MAX) begin
                  state_d = S_DONE;
                  done_d  = 1'b1;
               end else begin
                  if (col_q == POS_MAX) begin
                     col_d = '0;
                     row_d = row_q + CW'(1);
                  end else begin
                     col_d = col_q + CW'(1);
                  end
                  tap_d    = '0;
                  state_d  = S_READ;
                  issue_en = 1'b1;
                  issue_r  = row_d;
                  issue_c  = col_d;
               end
            end
         end
         S_DONE:  state_d = S_IDLE;
         default: state_d = S_IDLE;
      endcase

      issue = tap_issue(issue_base, issue_r, issue_c, issue_k);
      if (issue_en) begin
         re_p_d = issue[AW];
         if (issue[AW]) raddr_d = issue[AW-1:0];
      end

      if (cap_en) begin
         for (int s = 0; s < 9; s++) begin
            if (cap_k == 4'(s)) win_d[SIZE_9-1-SIZE*s -: SIZE] = cap_dat;
         end
      end

      busy_d = (state_d != S_IDLE);
`ifdef ZERO_PAD_EN
      rd_dly_d = re_p_q;
`endif
   end

   always_ff @(posedge clk) begin
      if (!rst_n) begin
         state_q     <= S_IDLE;
         tap_q       <= '0;
         row_q       <= '0;
         col_q       <= '0;
         base_q      <= '0;
         re_p_q      <= 1'b0;
         raddr_q     <= '0;
         win_q       <= '0;
         win_valid_q <= 1'b0;
         done_q      <= 1'b0;
         busy_q      <= 1'b0;
`ifdef ZERO_PAD_EN
         rd_dly_q    <= 1'b0;
`endif
      end else begin
         state_q     <= state_d;
         tap_q       <= tap_d;
         row_q       <= row_d;
         col_q       <= col_d;
         base_q      <= base_d;
         re_p_q      <= re_p_d;
         raddr_q     <= raddr_d;
         win_q       <= win_d;
         win_valid_q <= win_valid_d;
         done_q      <= done_d;
         busy_q      <= busy_d;
`ifdef ZERO_PAD_EN
         rd_dly_q    <= rd_dly_d;
`endif
      end
   end

   assign re_p          = re_p_q;
   assign read_addressp = raddr_q;
   assign win           = win_q;
   assign win_valid     = win_valid_q;
   assign done          = done_q;
   assign busy          = busy_q;

endmodule

// File: tb/tb_window_fetch.sv
// Bench for window_fetch: instance 0 uses MATRIX=4 (base 0), instance 1 uses MATRIX=28 (base 100).
module tb_window_fetch;

`ifdef ZERO_PAD_EN
   localparam int PAD = 1, WA = 16, R0 = 4, WB = 784, BCYC = 8625;
`else
   localparam int PAD = 0, WA = 4,  R0 = 9, WB = 676, BCYC = 7437;
`endif

   logic         clk;
   logic         rst_n     [2];
   logic         go        [2];
   logic [12:0]  base_addr [2];
   logic         re_p      [2];
   logic [12:0]  raddr     [2];
   logic [12:0]  qp        [2];
   logic [116:0] win       [2];
   logic         win_valid [2];
   logic         rdy       [2];
   logic         done      [2];
   logic         busy      [2];

   for (genvar g = 0; g < 2; g++) begin : g_dut
      window_fetch #(.MATRIX(g == 0 ? 4 : 28)) u_dut (
         .clk(clk), .rst_n(rst_n[g]), .go(go[g]), .base_addr(base_addr[g]),
         .re_p(re_p[g]), .read_addressp(raddr[g]), .qp(qp[g]),
         .win(win[g]), .win_valid(win_valid[g]), .win_ready(rdy[g]),
         .done(done[g]), .busy(busy[g]));
   end

   initial begin
      clk = 1'b0;
      forever #5 clk = ~clk;
   end

   int n_chk = 0, n_pass = 0;

   task automatic check(input string nm, input logic [127:0] act, input logic [127:0] exp);
      n_chk++;
      if (act === exp) n_pass++;
      else $display("FAIL %s: got 0x%0h, want 0x%0h", nm, act, exp);
   endtask

   task automatic note_fail(input string nm, input int act, input int exp);
      n_chk++;
      $display("FAIL %s: got %0d, want %0d", nm, act, exp);
   endtask

   // ---------------- reference model ----------------
   function automatic int mval(input int d, input int a);
      if (d == 0) return (PAD != 0) ? ((a + 1) & 8191) : (a & 8191);
      return (a * 7 + 3) & 8191;
   endfunction

   function automatic int side(input int d);
      return (d == 0) ? 4 : 28;
   endfunction

   function automatic int npos(input int d);
      return (PAD != 0) ? side(d) : side(d) - 2;
   endfunction

   function automatic int nwin(input int d);
      return npos(d) * npos(d);
   endfunction

   function automatic bit tap_at(input int d, input int base, input int n, input int k, output int a);
      int m, r, c;
      m = side(d);
      r = n / npos(d) + k / 3 - PAD;
      c = n % npos(d) + k % 3 - PAD;
      a = (base + r * m + c) & 8191;
      return (r >= 0) && (r < m) && (c >= 0) && (c < m);
   endfunction

   function automatic logic [116:0] ewin(input int d, input int base, input int n);
      logic [116:0] w;
      int a;
      w = '0;
      for (int k = 0; k < 9; k++)
         if (tap_at(d, base, n, k, a)) w[116-13*k -: 13] = 13'(mval(d, a));
      return w;
   endfunction

   function automatic logic [116:0] pk(input int t0, input int t1, input int t2, input int t3,
                                       input int t4, input int t5, input int t6, input int t7, input int t8);
      return {13'(t0), 13'(t1), 13'(t2), 13'(t3), 13'(t4), 13'(t5), 13'(t6), 13'(t7), 13'(t8)};
   endfunction

   // picture RAM: registered read
   always @(posedge clk)
      for (int d = 0; d < 2; d++)
         if (re_p[d]) qp[d] <= 13'(mval(d, int'(raddr[d])));

   // ---------------- per-cycle compare ----------------
   int           exp_base [2];
   int           expq [$];
   int           q_dut = 0;
   int           cyc = 0;
   int           acc [2], rd_win0 [2], maxa [2], bcyc [2], done_cnt [2], period [2], lastacc [2];
   bit           pend_done [2], prev_hold [2], prev_busy [2];
   logic [116:0] first_win [2], last_win [2];

   always @(negedge clk) begin : cmp
      int a;
      cyc++;
      for (int d = 0; d < 2; d++) begin
         if (!rst_n[d]) begin
            if (q_dut == d) expq.delete();
            acc[d] = 0; pend_done[d] = 0; prev_hold[d] = 0; prev_busy[d] = 0;
         end else begin
            if (busy[d] && !prev_busy[d]) begin
               expq.delete();
               q_dut = d;
               for (int n = 0; n < nwin(d); n++)
                  for (int k = 0; k < 9; k++)
                     if (tap_at(d, exp_base[d], n, k, a)) expq.push_back(a);
               acc[d] = 0; rd_win0[d] = 0; maxa[d] = 0; bcyc[d] = 0; done_cnt[d] = 0;
            end
            prev_busy[d] = busy[d];
            if (busy[d]) bcyc[d]++;
            if (re_p[d]) begin
               if (expq.size() == 0 || q_dut != d) note_fail("extra_read", int'(raddr[d]), -1);
               else begin
                  a = expq.pop_front();
                  check("read_addr", raddr[d], a);
               end
               if (int'(raddr[d]) > maxa[d]) maxa[d] = int'(raddr[d]);
               if (acc[d] == 0) rd_win0[d]++;
            end
            if (prev_hold[d]) check("hold_valid", win_valid[d], 1);
            if (win_valid[d]) begin
               check("re_p_in_hold", re_p[d], 0);
               check("win", win[d], ewin(d, exp_base[d], acc[d]));
            end
            if (done[d] || pend_done[d]) begin
               check("done_pulse", {done[d], pend_done[d]}, 2'b11);
               if (done[d]) done_cnt[d]++;
            end
            pend_done[d] = 0;
            if (win_valid[d] && rdy[d]) begin
               if (acc[d] == 0) first_win[d] = win[d];
               last_win[d] = win[d];
               if (acc[d] == nwin(d) - 1) pend_done[d] = 1;
               period[d]  = cyc - lastacc[d];
               lastacc[d] = cyc;
               acc[d]++;
            end
            prev_hold[d] = win_valid[d] && !rdy[d];
         end
      end
   end

   // ---------------- stimulus ----------------
   task automatic run_go(input int d, input int base);
      exp_base[d] = base;
      @(posedge clk); #1;
      go[d] = 1'b1;
      base_addr[d] = 13'(base);
      @(posedge clk); #1;
      go[d] = 1'b0;
   endtask

   task automatic wait_done(input int d, input int budget);
      bit seen = 0;
      for (int i = 0; i < budget && !seen; i++) begin
         @(negedge clk);
         if (done[d]) seen = 1;
      end
      if (!seen) note_fail("done_timeout", 0, 1);
   endtask

   logic [116:0] f1, l1;

   initial begin
`ifdef ZERO_PAD_EN
      f1 = pk(0, 0, 0, 0, 1, 2, 0, 5, 6);
      l1 = pk(11, 12, 0, 15, 16, 0, 0, 0, 0);
`else
      f1 = pk(0, 1, 2, 4, 5, 6, 8, 9, 10);
      l1 = pk(5, 6, 7, 9, 10, 11, 13, 14, 15);
`endif
      for (int d = 0; d < 2; d++) begin
         rst_n[d] = 1'b0; go[d] = 1'b0; base_addr[d] = '0; rdy[d] = 1'b1; exp_base[d] = 0;
      end

      // reset state
      repeat (3) @(posedge clk);
      @(negedge clk);
      check("rst_re_p", re_p[0], 0);
      check("rst_addr", raddr[0], 0);
      check("rst_win", win[0], 0);
      check("rst_valid", win_valid[0], 0);
      check("rst_done", done[0], 0);
      check("rst_busy", busy[0], 0);
      @(posedge clk); #1;
      rst_n[0] = 1'b1; rst_n[1] = 1'b1;

      // full pass, ready always high
      run_go(0, 0);
      wait_done(0, 400);
      repeat (3) @(negedge clk);
      check("t1_windows", acc[0], WA);
      check("t1_first_win", first_win[0], f1);
      check("t1_last_win", last_win[0], l1);
      check("t1_win0_reads", rd_win0[0], R0);
      check("t1_done_count", done_cnt[0], 1);
      check("t1_reads_left", expq.size(), 0);

      // backpressure in HOLD
      rdy[0] = 1'b0;
      run_go(0, 0);
      begin
         bit seen = 0;
         for (int i = 0; i < 50 && !seen; i++) begin
            @(negedge clk);
            if (win_valid[0]) seen = 1;
         end
         if (!seen) note_fail("t2_valid_timeout", 0, 1);
      end
      repeat (20) @(negedge clk);
      check("t2_valid_held", win_valid[0], 1);
      check("t2_re_p_low", re_p[0], 0);
      @(posedge clk); #1;
      rdy[0] = 1'b1;
      begin
         bit seen = 0;
         for (int i = 0; i < 60 && !seen; i++) begin
            @(negedge clk);
            if (acc[0] >= 2) seen = 1;
         end
         if (!seen) note_fail("t2_accept_timeout", acc[0], 2);
      end
      check("t2_period", period[0], 11);
      wait_done(0, 400);
      repeat (2) @(negedge clk);
      check("t2_windows", acc[0], WA);

      // go pulses while busy and in DONE are ignored
      run_go(0, 0);
      for (int i = 0; i < 6; i++) begin
         repeat (4) @(posedge clk);
         #1; go[0] = 1'b1; base_addr[0] = 13'd50;
         @(posedge clk); #1; go[0] = 1'b0;
      end
      begin
         bit seen = 0;
         for (int i = 0; i < 400 && !seen; i++) begin
            @(negedge clk);
            if (done[0]) seen = 1;
         end
         if (!seen) note_fail("t5_done_timeout", 0, 1);
      end
      go[0] = 1'b1;
      @(posedge clk); #1;
      go[0] = 1'b0;
      repeat (5) @(negedge clk);
      check("t5_idle_after_done", busy[0], 0);
      check("t5_windows", acc[0], WA);
      check("t5_done_count", done_cnt[0], 1);

      // reset in the tap-4 read cycle, then restart
      run_go(0, 0);
      repeat (4) @(posedge clk);
      #1; rst_n[0] = 1'b0;
      @(posedge clk);
      @(negedge clk);
      check("t4_re_p", re_p[0], 0);
      check("t4_addr", raddr[0], 0);
      check("t4_win", win[0], 0);
      check("t4_valid", win_valid[0], 0);
      check("t4_done", done[0], 0);
      check("t4_busy", busy[0], 0);
      @(posedge clk); #1;
      rst_n[0] = 1'b1;
      run_go(0, 0);
      wait_done(0, 400);
      repeat (2) @(negedge clk);
      check("t4_restart_first", first_win[0], f1);
      check("t4_restart_windows", acc[0], WA);

      // MATRIX=28 full pass
      run_go(1, 100);
      wait_done(1, 12000);
      repeat (3) @(negedge clk);
      check("t3_windows", acc[1], WB);
      check("t3_max_addr", maxa[1], 883);
      check("t3_done_count", done_cnt[1], 1);
      check("t3_busy_cycles", bcyc[1], BCYC);
      check("t3_reads_left", expq.size(), 0);

      $display("%0d/%0d checks passed", n_pass, n_chk);
      $finish;
   end

endmodule
